// File: rtl/hdu_pkg.sv
// Shared types and default sizing for the hazard detection unit.
package hdu_pkg;

    typedef enum logic [1:0] {
        FWD_NONE  = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    localparam int LATW_DEF      = 4;
    localparam int NOFWD_LAT_DEF = 3;

endpackage

// File: rtl/hdu_fwd_sel.sv
// Forwarding select for one EX operand: EX/MEM result wins over MEM/WB.
module hdu_fwd_sel import hdu_pkg::*; #(
    parameter int REGW = 5
) (
    input  logic            fwd_en,
    input  logic [REGW-1:0] src,
    input  logic [REGW-1:0] exmem_rd,
    input  logic            exmem_regWrite,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            memwb_regWrite,
    output fwd_sel_t        sel
);

    // Priority compare; x0 is never a forwarding source.
    always_comb begin
        sel = FWD_NONE;
        if (fwd_en && exmem_regWrite && exmem_rd != '0 && exmem_rd == src)
            sel = FWD_EXMEM;
        else if (fwd_en && memwb_regWrite && memwb_rd != '0 && memwb_rd == src)
            sel = FWD_MEMWB;
    end

endmodule

// File: rtl/hdu_scoreboard.sv
// Countdown-scoreboard hazard unit: RAW/WAW stalls, flush cancel, forwarding.
module hdu_scoreboard import hdu_pkg::*; #(
    parameter int NREG      = 32,
    parameter int REGW      = $clog2(NREG),
    parameter int LATW      = LATW_DEF,
    parameter int NOFWD_LAT = NOFWD_LAT_DEF,
    parameter int CNTW      = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            fwd_en,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rs1,
    input  logic [REGW-1:0] id_rs2,
    input  logic            id_use_rs1,
    input  logic            id_use_rs2,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_regWrite,
    input  logic [LATW-1:0] id_lat,
    input  logic            flush,
    input  logic [REGW-1:0] idex_rs1,
    input  logic [REGW-1:0] idex_rs2,
    input  logic [REGW-1:0] exmem_rd,
    input  logic [REGW-1:0] memwb_rd,
    input  logic            exmem_regWrite,
    input  logic            memwb_regWrite,
    output logic [1:0]      forwA,
    output logic [1:0]      forwB,
    output logic            stall,
    output logic            issue,
    output logic [NREG-1:0] busy_vec,
    output logic [CNTW-1:0] stall_cnt
);

    logic [NREG-1:0][LATW-1:0] sb;
    logic                      owner_vld;
    logic [REGW-1:0]           owner_rd;
    logic [LATW:0]             lat_ext;
    logic [LATW-1:0]           load_val;
    logic                      raw, waw;
    fwd_sel_t                  sel_a, sel_b;

    hdu_fwd_sel #(.REGW(REGW)) u_fwd_a (
        .fwd_en(fwd_en), .src(idex_rs1),
        .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite),
        .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
        .sel(sel_a)
    );

    hdu_fwd_sel #(.REGW(REGW)) u_fwd_b (
        .fwd_en(fwd_en), .src(idex_rs2),
        .exmem_rd(exmem_rd), .exmem_regWrite(exmem_regWrite),
        .memwb_rd(memwb_rd), .memwb_regWrite(memwb_regWrite),
        .sel(sel_b)
    );

    assign forwA = sel_a;
    assign forwB = sel_b;

    // Load value: without forwarding the result only appears after the regfile
    // write/read, so latency is stretched; the extra bit catches overflow.
    always_comb begin
        lat_ext  = {1'b0, id_lat} + (fwd_en ? '0 : (LATW+1)'(NOFWD_LAT));
        load_val = lat_ext[LATW] ? '1 : lat_ext[LATW-1:0];
    end

    // Hazards: sb[0] stays zero, so x0 sources never stall.
    always_comb begin
        raw = id_valid && ((id_use_rs1 && sb[id_rs1] != '0) ||
                           (id_use_rs2 && sb[id_rs2] != '0));
        waw = id_valid && id_regWrite && (id_rd != '0) && (sb[id_rd] > load_val);
    end

    assign stall = raw || waw;
    assign issue = id_valid && !stall && !flush;

    for (genvar r = 0; r < NREG; r++) begin : g_busy
        assign busy_vec[r] = |sb[r];
    end

    // Per-register countdown: a new issue reloads, a flush of the owner
    // cancels, otherwise count down towards idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb <= '0;
        end else begin
            sb[0] <= '0;
            for (int r = 1; r < NREG; r++) begin
                if (issue && id_regWrite && id_rd == REGW'(r))
                    sb[r] <= load_val;
                else if (flush && owner_vld && owner_rd == REGW'(r))
                    sb[r] <= '0;
                else if (sb[r] != '0)
                    sb[r] <= sb[r] - LATW'(1);
            end
        end
    end

    // Remember which entry the instruction now entering ID/EX owns.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_vld <= 1'b0;
            owner_rd  <= '0;
        end else begin
            owner_vld <= issue && id_regWrite && (id_rd != '0);
            owner_rd  <= id_rd;
        end
    end

    // Saturating stall-cycle counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall && id_valid && stall_cnt != '1)
            stall_cnt <= stall_cnt + CNTW'(1);
    end

endmodule

// File: tb/tb_hdu_scoreboard.sv
// Self-checking bench for hdu_scoreboard against a per-register latency model.
module tb_hdu_scoreboard;

    localparam int NREG = 32;
    localparam int REGW = 5;

    logic            clk = 1'b0, rst_n = 1'b0, fwd_en = 1'b1;
    logic            id_valid = 1'b0, id_use_rs1 = 1'b0, id_use_rs2 = 1'b0, id_regWrite = 1'b0;
    logic [REGW-1:0] id_rs1 = '0, id_rs2 = '0, id_rd = '0;
    logic [3:0]      id_lat = '0;
    logic            flush = 1'b0;
    logic [REGW-1:0] idex_rs1 = '0, idex_rs2 = '0, exmem_rd = '0, memwb_rd = '0;
    logic            exmem_regWrite = 1'b0, memwb_regWrite = 1'b0;
    logic [1:0]      forwA, forwB;
    logic            stall, issue;
    logic [NREG-1:0] busy_vec;
    logic [31:0]     stall_cnt;

    hdu_scoreboard dut (
        .clk(clk), .rst_n(rst_n), .fwd_en(fwd_en), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .id_rd(id_rd), .id_regWrite(id_regWrite), .id_lat(id_lat), .flush(flush),
        .idex_rs1(idex_rs1), .idex_rs2(idex_rs2), .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
        .exmem_regWrite(exmem_regWrite), .memwb_regWrite(memwb_regWrite),
        .forwA(forwA), .forwB(forwB), .stall(stall), .issue(issue),
        .busy_vec(busy_vec), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: remaining cycles per register, owner of ID/EX, stall count.
    int     sbm [NREG];
    bit     own_v;
    int     own_r;
    longint cnt_m;
    int     pass_n = 0, total_n = 0;

    wire [37:0] dut_vec = {stall, issue, busy_vec, forwA, forwB};

    function automatic int lv_m();
        int v = fwd_en ? int'(id_lat) : int'(id_lat) + 3;
        return (v > 15) ? 15 : v;
    endfunction

    function automatic bit stall_m();
        bit raw, waw;
        raw = id_valid && ((id_use_rs1 && sbm[id_rs1] != 0) || (id_use_rs2 && sbm[id_rs2] != 0));
        waw = id_valid && id_regWrite && id_rd != 0 && sbm[id_rd] > lv_m();
        return raw || waw;
    endfunction

    function automatic bit issue_m();
        return id_valid && !stall_m() && !flush;
    endfunction

    function automatic logic [1:0] fwd_m(input logic [REGW-1:0] src);
        if (fwd_en && exmem_regWrite && exmem_rd != 0 && exmem_rd == src) return 2'b01;
        if (fwd_en && memwb_regWrite && memwb_rd != 0 && memwb_rd == src) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [37:0] exp_vec();
        logic [NREG-1:0] b;
        for (int r = 0; r < NREG; r++) b[r] = (sbm[r] != 0);
        return {stall_m(), issue_m(), b, fwd_m(idex_rs1), fwd_m(idex_rs2)};
    endfunction

    task automatic model_clear();
        for (int r = 0; r < NREG; r++) sbm[r] = 0;
        own_v = 0; own_r = 0; cnt_m = 0;
    endtask

    // One rising edge, with the model advanced from the inputs held across it.
    task automatic tick();
        bit st, is;
        int nv;
        st = stall_m(); is = issue_m(); nv = lv_m();
        @(posedge clk);
        for (int r = 1; r < NREG; r++) begin
            if (is && id_regWrite && id_rd == r) sbm[r] = nv;
            else if (flush && own_v && own_r == r) sbm[r] = 0;
            else if (sbm[r] > 0) sbm[r] = sbm[r] - 1;
        end
        own_v = is && id_regWrite && id_rd != 0;
        own_r = int'(id_rd);
        if (st && id_valid && cnt_m < 64'hFFFF_FFFF) cnt_m++;
        #1;
    endtask

    task automatic set_id(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                          input int rd, input bit rw, input int lat);
        id_valid = v; id_rs1 = rs1[REGW-1:0]; id_use_rs1 = u1;
        id_rs2 = rs2[REGW-1:0]; id_use_rs2 = u2;
        id_rd = rd[REGW-1:0]; id_regWrite = rw; id_lat = lat[3:0];
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0, 0, 0);
        flush = 0;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        rst_n = 0;
        #2 rst_n = 1;
        model_clear();
        tick();
    endtask

    task automatic test_reset();
        set_id(1, 1, 1, 2, 1, 3, 1, 2);
        #3;
        total_n++;
        if ({stall, issue, busy_vec} !== {1'b0, 1'b1, 32'b0})
            $display("FAIL reset_outputs: got stall/issue/busy %h expected %h", {stall, issue, busy_vec}, {1'b0, 1'b1, 32'b0});
        else pass_n++;
        total_n++;
        if (stall_cnt !== 32'd0) $display("FAIL reset_cnt: got %0d expected 0", stall_cnt);
        else pass_n++;
        do_reset();
    endtask

    task automatic test_fwd_priority();
        do_reset();
        fwd_en = 1; exmem_rd = 7; memwb_rd = 7; exmem_regWrite = 1; memwb_regWrite = 1;
        idex_rs1 = 7; idex_rs2 = 7;
        #1 total_n++;
        if ({forwA, forwB} !== 4'b0101) $display("FAIL fwd_exmem: got %b expected 0101", {forwA, forwB});
        else pass_n++;
        exmem_regWrite = 0;
        #1 total_n++;
        if (forwA !== 2'b10) $display("FAIL fwd_memwb: got %b expected 10", forwA);
        else pass_n++;
        fwd_en = 0;
        #1 total_n++;
        if (forwA !== 2'b00) $display("FAIL fwd_disabled: got %b expected 00", forwA);
        else pass_n++;
        fwd_en = 1; exmem_regWrite = 1; exmem_rd = 0; memwb_rd = 0; idex_rs1 = 0;
        #1 total_n++;
        if (forwA !== 2'b00) $display("FAIL fwd_x0: got %b expected 00", forwA);
        else pass_n++;
        exmem_regWrite = 0; memwb_regWrite = 0; idex_rs1 = 0; idex_rs2 = 0;
    endtask

    task automatic test_load_use();
        do_reset();
        set_id(1, 0, 0, 0, 0, 5, 1, 1);
        tick();
        set_id(1, 5, 1, 0, 0, 6, 0, 0);
        @(negedge clk) total_n++;
        if (stall !== 1'b1) $display("FAIL load_use_stall: got %b expected 1", stall);
        else pass_n++;
        tick();
        @(negedge clk) total_n++;
        if ({stall, issue, stall_cnt} !== {1'b0, 1'b1, 32'd1})
            $display("FAIL load_use_issue: got %h expected %h", {stall, issue, stall_cnt}, {1'b0, 1'b1, 32'd1});
        else pass_n++;
        tick();
        idle();
    endtask

    task automatic test_div();
        int ns = 0, nb = 0;
        bit done;
        do_reset();
        set_id(1, 0, 0, 0, 0, 10, 1, 4);
        tick();
        set_id(1, 10, 1, 0, 0, 0, 0, 0);
        for (int c = 0; c < 8; c++) begin
            @(negedge clk) total_n++;
            if (dut_vec !== exp_vec()) $display("FAIL div_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
            else pass_n++;
            ns += int'(stall); nb += int'(busy_vec[10]); done = issue;
            tick();
            if (done) idle();
        end
        total_n++;
        if ({ns, nb} !== {32'd4, 32'd4}) $display("FAIL div_counts: got stalls %0d busy %0d expected 4 4", ns, nb);
        else pass_n++;
        total_n++;
        if (stall_cnt !== 32'd4) $display("FAIL div_stall_cnt: got %0d expected 4", stall_cnt);
        else pass_n++;
    endtask

    task automatic test_waw();
        int ns = 0;
        bit got = 0;
        do_reset();
        set_id(1, 0, 0, 0, 0, 3, 1, 5);
        tick();
        set_id(1, 0, 0, 0, 0, 3, 1, 1);
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk) total_n++;
            if (dut_vec !== exp_vec()) $display("FAIL waw_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
            else pass_n++;
            ns += int'(stall); got = issue;
            tick();
        end
        idle();
        total_n++;
        if ({got, ns} !== {1'b1, 32'd4}) $display("FAIL waw_stalls: got issued %b stalls %0d expected 1 4", got, ns);
        else pass_n++;
        @(negedge clk) total_n++;
        if (busy_vec[3] !== 1'b1) $display("FAIL waw_reload: got %b expected 1", busy_vec[3]);
        else pass_n++;
        tick();
        @(negedge clk) total_n++;
        if (busy_vec[3] !== 1'b0) $display("FAIL waw_drain: got %b expected 0", busy_vec[3]);
        else pass_n++;
    endtask

    task automatic test_flush();
        do_reset();
        set_id(1, 0, 0, 0, 0, 8, 1, 3);
        tick();
        idle(); flush = 1;
        tick();
        flush = 0;
        set_id(1, 8, 1, 0, 0, 0, 0, 0);
        @(negedge clk) total_n++;
        if ({busy_vec[8], stall, issue} !== 3'b001)
            $display("FAIL flush_clear: got busy/stall/issue %b expected 001", {busy_vec[8], stall, issue});
        else pass_n++;
        tick();
        // flush coinciding with a stall still clears the owner entry
        set_id(1, 0, 0, 0, 0, 9, 1, 3);
        tick();
        set_id(1, 9, 1, 0, 0, 0, 0, 0); flush = 1;
        @(negedge clk) total_n++;
        if ({stall, issue} !== 2'b10) $display("FAIL flush_stall: got %b expected 10", {stall, issue});
        else pass_n++;
        tick();
        idle();
        @(negedge clk) total_n++;
        if (busy_vec[9] !== 1'b0) $display("FAIL flush_stall_clear: got %b expected 0", busy_vec[9]);
        else pass_n++;
    endtask

    task automatic test_x0_sat();
        int nb = 0;
        do_reset();
        set_id(1, 0, 0, 0, 0, 0, 1, 4);
        tick();
        set_id(1, 0, 1, 0, 1, 0, 1, 4);
        @(negedge clk) total_n++;
        if ({busy_vec, stall, issue} !== {32'b0, 1'b0, 1'b1})
            $display("FAIL x0: got %h expected %h", {busy_vec, stall, issue}, {32'b0, 1'b0, 1'b1});
        else pass_n++;
        tick();
        fwd_en = 0;
        set_id(1, 0, 0, 0, 0, 9, 1, 15);
        tick();
        idle(); fwd_en = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk) total_n++;
            if (dut_vec !== exp_vec()) $display("FAIL sat_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
            else pass_n++;
            nb += int'(busy_vec[9]);
            tick();
        end
        total_n++;
        if (nb !== 15) $display("FAIL sat_len: got %0d busy cycles expected 15", nb);
        else pass_n++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_id(1, 0, 0, 0, 0, 12, 1, 6);
        tick();
        set_id(1, 12, 1, 0, 0, 0, 0, 0);
        tick(); tick();
        @(negedge clk) total_n++;
        if ({stall, stall_cnt} !== {1'b1, 32'd2}) $display("FAIL pre_reset: got %h expected %h", {stall, stall_cnt}, {1'b1, 32'd2});
        else pass_n++;
        #2 rst_n = 0;
        #1 total_n++;
        if ({stall, stall_cnt, busy_vec} !== 65'd0)
            $display("FAIL async_reset: got %h expected 0", {stall, stall_cnt, busy_vec});
        else pass_n++;
        model_clear();
        idle();
        #1 rst_n = 1;
        tick();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            set_id(($urandom % 4) != 0, int'($urandom % 8), $urandom % 2, int'($urandom % 8), $urandom % 2,
                   int'($urandom % 8), $urandom % 2,
                   (($urandom % 4) == 0) ? int'($urandom % 16) : int'($urandom % 3));
            fwd_en = ($urandom % 8) != 0;
            flush = ($urandom % 10) == 0;
            idex_rs1 = 5'($urandom % 8); idex_rs2 = 5'($urandom % 8);
            exmem_rd = 5'($urandom % 8); memwb_rd = 5'($urandom % 8);
            exmem_regWrite = $urandom % 2; memwb_regWrite = $urandom % 2;
            @(negedge clk) total_n++;
            if (dut_vec !== exp_vec()) $display("FAIL rand_cycle%0d: got %h expected %h", c, dut_vec, exp_vec());
            else pass_n++;
            total_n++;
            if (stall_cnt !== cnt_m[31:0]) $display("FAIL rand_cnt%0d: got %0d expected %0d", c, stall_cnt, cnt_m);
            else pass_n++;
            tick();
        end
        idle();
        fwd_en = 1;
    endtask

    initial begin
        model_clear();
        test_reset();
        test_fwd_priority();
        test_load_use();
        test_div();
        test_waw();
        test_flush();
        test_x0_sat();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
